// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and sizing helpers for the UART transmit scheduler.
// Imported by the scheduler, its holding slots and the interface users.
package uart_ctrl_pkg;

  localparam int DEF_RESULT_BYTES = 4;
  localparam int DEF_GUARD_CYCLES = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    ACK   = 2'd2,
    DRAIN = 2'd3
  } tx_state_e;

  typedef enum logic {
    GRANT_STS = 1'b0,
    GRANT_RES = 1'b1
  } grant_e;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BYTE_CNT_W  = cnt_width(DEF_RESULT_BYTES);
  localparam int GUARD_CNT_W = cnt_width(DEF_GUARD_CYCLES + 1);

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester slots and UART core transmit port of the scheduler.
// master = requesters plus core side stimulus, slave = scheduler.
interface uart_tx_sched_if #(
  parameter int RESULT_BYTES = 4
) ();

  logic                      res_valid;
  logic [8*RESULT_BYTES-1:0] res_data;
  logic                      res_ready;
  logic                      sts_valid;
  logic [7:0]                sts_code;
  logic                      sts_ready;
  logic                      txrdy;
  logic [7:0]                tx_data;
  logic                      wen;

  modport master (
    output res_valid, res_data, sts_valid, sts_code, txrdy,
    input  res_ready, sts_ready, tx_data, wen
  );

  modport slave (
    input  res_valid, res_data, sts_valid, sts_code, txrdy,
    output res_ready, sts_ready, tx_data, wen
  );

endinterface

// File: rtl/uart_tx_scheduler_hold_slot.sv
// One-deep valid/ready holding register; stays full until the owner
// releases it, and reports not-ready while reset is asserted.
module tx_hold_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  input  logic             rel,
  output logic             full,
  output logic [WIDTH-1:0] held
);

  logic             full_r;
  logic [WIDTH-1:0] data_r;

  assign ready = reset_n && !full_r;
  assign full  = full_r;
  assign held  = data_r;

  // Capture when empty and offered; clear on release from the scheduler.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_r <= 1'b0;
      data_r <= '0;
    end else if (valid && ready) begin
      full_r <= 1'b1;
      data_r <= data;
    end else if (rel) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares the UART core transmit port between a multi-byte result requester
// and a single-byte status requester, one byte per wen strobe.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int RESULT_BYTES = DEF_RESULT_BYTES,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_tx_sched_if.slave bus,
  output logic           busy,
  output logic           grant_res
);

  localparam int RES_W = 8 * RESULT_BYTES;
  localparam int BCW   = cnt_width(RESULT_BYTES);
  localparam int GCW   = cnt_width(GUARD_CYCLES + 1);
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(RESULT_BYTES - 1);
  localparam logic [GCW-1:0] GUARD_MAX = GCW'(GUARD_CYCLES);

  tx_state_e        state_r, state_s;
  logic [BCW-1:0]   byte_cnt_r, byte_cnt_s;
  logic [GCW-1:0]   guard_cnt_r, guard_cnt_s;
  grant_e           last_grant_r, last_grant_s;
  logic             grant_res_r, grant_res_s;
  logic [7:0]       tx_data_r, tx_data_s;
  logic             wen_r, wen_s;
  logic             busy_r;
  logic             res_ready_s, sts_ready_s;
  logic             res_full_s, sts_full_s;
  logic             res_rel_s, sts_rel_s;
  logic [RES_W-1:0] res_held_s;
  logic [7:0]       sts_held_s;
  logic [7:0]       cur_byte_s;

  tx_hold_slot #(.WIDTH(RES_W)) u_res_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (bus.res_valid),
    .data    (bus.res_data),
    .ready   (res_ready_s),
    .rel     (res_rel_s),
    .full    (res_full_s),
    .held    (res_held_s)
  );

  tx_hold_slot #(.WIDTH(8)) u_sts_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (bus.sts_valid),
    .data    (bus.sts_code),
    .ready   (sts_ready_s),
    .rel     (sts_rel_s),
    .full    (sts_full_s),
    .held    (sts_held_s)
  );

  assign bus.res_ready = res_ready_s;
  assign bus.sts_ready = sts_ready_s;
  assign bus.tx_data   = tx_data_r;
  assign bus.wen       = wen_r;
  assign busy          = busy_r;
  assign grant_res     = grant_res_r;

  // Byte presented to the core: result bytes count down, so MSB goes first.
  always_comb begin
    cur_byte_s = sts_held_s;
    if (grant_res_r) begin
      cur_byte_s = res_held_s[{byte_cnt_r, 3'b000} +: 8];
    end else begin
      cur_byte_s = sts_held_s;
    end
  end

  // Next-state and next-output logic of the frame sequencer.
  always_comb begin
    state_s      = state_r;
    byte_cnt_s   = byte_cnt_r;
    guard_cnt_s  = guard_cnt_r;
    last_grant_s = last_grant_r;
    grant_res_s  = grant_res_r;
    tx_data_s    = tx_data_r;
    wen_s        = 1'b1;
    res_rel_s    = 1'b0;
    sts_rel_s    = 1'b0;
    case (state_r)
      IDLE: begin
        // On a tie the requester that did not send the last frame wins.
        if (res_full_s && (!sts_full_s || (last_grant_r == GRANT_STS))) begin
          grant_res_s = 1'b1;
          byte_cnt_s  = BYTE_LAST;
          state_s     = SEND;
        end else if (sts_full_s) begin
          grant_res_s = 1'b0;
          byte_cnt_s  = '0;
          state_s     = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (bus.txrdy) begin
          tx_data_s   = cur_byte_s;
          wen_s       = 1'b0;
          guard_cnt_s = '0;
          state_s     = ACK;
        end else begin
          state_s = SEND;
        end
      end
      ACK: begin
        // A core that accepts instantly may never drop txrdy; the guard bounds that wait.
        if (!bus.txrdy || (guard_cnt_r == GUARD_MAX)) begin
          state_s = DRAIN;
        end else begin
          guard_cnt_s = guard_cnt_r + {{(GCW-1){1'b0}}, 1'b1};
          state_s     = ACK;
        end
      end
      DRAIN: begin
        if (!bus.txrdy) begin
          state_s = DRAIN;
        end else if (byte_cnt_r != '0) begin
          byte_cnt_s = byte_cnt_r - {{(BCW-1){1'b0}}, 1'b1};
          state_s    = SEND;
        end else begin
          res_rel_s    = grant_res_r;
          sts_rel_s    = !grant_res_r;
          last_grant_s = grant_res_r ? GRANT_RES : GRANT_STS;
          state_s      = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state and registered core-facing outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      byte_cnt_r   <= '0;
      guard_cnt_r  <= '0;
      last_grant_r <= GRANT_STS;
      grant_res_r  <= 1'b0;
      tx_data_r    <= 8'h00;
      wen_r        <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      byte_cnt_r   <= byte_cnt_s;
      guard_cnt_r  <= guard_cnt_s;
      last_grant_r <= last_grant_s;
      grant_res_r  <= grant_res_s;
      tx_data_r    <= tx_data_s;
      wen_r        <= wen_s;
      busy_r       <= (state_s != IDLE);
    end
  end

endmodule
